// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial test-pattern transmitter, MSB-first, auto or manual ticks
// Optional continuous looping is enabled with `define SEQ_PATTERN_TX_LOOP_EN.
module seq_pattern_tx #(
    parameter int PATTERN_W = 16,
    parameter int DIV       = 50_000_000
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         mode,
    input  logic                         step,
`ifdef SEQ_PATTERN_TX_LOOP_EN
    input  logic                         loop,
`endif
    input  logic [PATTERN_W-1:0]         pattern_in,
    output logic                         A,
    output logic                         A_stb,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(PATTERN_W)-1:0] bit_cnt
);

    localparam int CW = $clog2(PATTERN_W);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PATTERN_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state;
    logic [PATTERN_W-1:0]  shreg;
    logic                  mode_r;
    logic [DW-1:0]         div_cnt;
    logic                  step_meta;
    logic                  step_sync;
    logic                  step_prev;
    logic                  tick;
    logic                  last_bit;
`ifdef SEQ_PATTERN_TX_LOOP_EN
    logic [PATTERN_W-1:0]  pat;
    logic                  loop_r;
`endif

    // shreg holds the bits still to be sent, next one in the MSB position
    always_comb begin
        tick     = mode_r ? (step_sync & ~step_prev) : (div_cnt == DIV_LAST);
        last_bit = (bit_cnt == CNT_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shreg     <= '0;
            mode_r    <= 1'b0;
            div_cnt   <= '0;
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
            A         <= 1'b0;
            A_stb     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_cnt   <= '0;
`ifdef SEQ_PATTERN_TX_LOOP_EN
            pat       <= '0;
            loop_r    <= 1'b0;
`endif
        end else begin
            // synchronizer runs in every state so no stale edge survives into a pass
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
            A_stb     <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= SHIFT;
                        shreg   <= pattern_in << 1;
                        mode_r  <= mode;
                        div_cnt <= '0;
                        A       <= pattern_in[PATTERN_W-1];
                        A_stb   <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
`ifdef SEQ_PATTERN_TX_LOOP_EN
                        pat     <= pattern_in;
                        loop_r  <= loop;
`endif
                    end
                end

                SHIFT: begin
                    div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
                    if (abort) begin
                        state   <= IDLE;
                        A       <= 1'b0;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else if (tick) begin
                        if (!last_bit) begin
                            A       <= shreg[PATTERN_W-1];
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + CW'(1);
                            A_stb   <= 1'b1;
                        end else begin
                            done <= 1'b1;
`ifdef SEQ_PATTERN_TX_LOOP_EN
                            if (loop_r) begin
                                A       <= pat[PATTERN_W-1];
                                shreg   <= pat << 1;
                                bit_cnt <= '0;
                                A_stb   <= 1'b1;
                            end else begin
                                state   <= IDLE;
                                A       <= 1'b0;
                                busy    <= 1'b0;
                                bit_cnt <= '0;
                            end
`else
                            state   <= IDLE;
                            A       <= 1'b0;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
`endif
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial test-pattern transmitter: the source end of the single-bit `A` stream consumed by the sequence-detector FSMs. Loads a parallel pattern and shifts it out MSB-first, one bit per tick. Ticks come from an internal divider (auto mode) or from an external step input (manual mode). Each new bit is marked by a one-cycle strobe, so Moore and Mealy detectors fed from this block see identical, reproducible stimulus.

## Interface
Parameters:
- `PATTERN_W`, 16: pattern length in bits, ≥2.
- `DIV`, 50_000_000: CLK cycles per bit tick in auto mode, ≥1.

Ports:
- `CLK` in 1: single clock, e.g. `Clock50M`.
- `RST` in 1: reset, synchronous and active-high.
- `start` in 1: begin transmission; level-sampled; accepted only in IDLE.
- `abort` in 1: terminate transmission; level-sampled.
- `mode` in 1: 0 = auto (divider ticks), 1 = manual (step ticks); captured at start.
- `step` in 1: asynchronous step input, e.g. raw switch or `rawclock`; rising edge = one tick in manual mode.
- `pattern_in` in `PATTERN_W`: pattern, captured at start.
- `A` out 1: serial output bit.
- `A_stb` out 1: one-cycle pulse in the cycle `A` takes a new bit.
- `busy` out 1: high in SHIFT.
- `done` out 1: one-cycle pulse at the end of a pass.
- `bit_cnt` out `$clog2(PATTERN_W)`: index of the bit currently on `A`, 0 = MSB.

## Operation
- States: IDLE, SHIFT.
- Reset (RST high at a CLK edge):
  - State → IDLE.
  - Outputs: `A`=0, `A_stb`=0, `busy`=0, `done`=0, `bit_cnt`=0.
  - Shift register, divider and step synchronizer all cleared.
- IDLE to SHIFT, when `start`=1 and `abort`=0:
  - Capture `pattern_in` into the shift register and capture `mode`.
  - Clear the divider.
  - Next cycle: `A`=`pattern_in[PATTERN_W-1]`, `bit_cnt`=0, `A_stb`=1, `busy`=1.
- SHIFT, on a tick when `bit_cnt` < `PATTERN_W-1`:
  - `A` ← next lower bit, `bit_cnt`+1, `A_stb`=1.
- SHIFT, on a tick when `bit_cnt` = `PATTERN_W-1`:
  - `done`=1 for one cycle, state → IDLE.
  - `A`=0, `bit_cnt`=0, `busy`=0.
  - No `A_stb`.
- Auto tick: divider counts 0..`DIV-1`; the tick fires in the cycle it wraps to 0. First tick occurs `DIV` cycles after the first-bit strobe.
- Manual tick:
  - `step` passes through a 2-FF synchronizer plus an edge register.
  - A tick is a synchronized 0→1 transition.
  - Divider is ignored.
- Boundary conditions:
  - `abort`=1 in SHIFT: IDLE next cycle, `A`=0, `busy`=0, no `done`, no `A_stb`; abort wins over a coincident tick.
  - `start` and `abort` both high in IDLE: start ignored.
  - `start` in SHIFT: ignored; `pattern_in`/`mode` changes mid-pass have no effect.
  - `start` held high: re-accepted in the cycle after `done`, i.e. back-to-back passes.
  - `step` edges in auto mode or in IDLE: discarded; synchronizer keeps running so no stale edge fires at start.
  - RST mid-pass: immediate return to reset values; no `done`.

## Timing
- `start` sampled at edge t → first bit on `A` with `A_stb` at t+1.
- Auto mode: bit k is presented from cycle t+1+k·`DIV`; `done` at t+1+`PATTERN_W`·`DIV`.
- Manual mode: `step` rising before edge s → `A` and `A_stb` update at s+3.
- `A` is stable between strobes. All outputs are registered; no combinational input→output paths.
- Max one tick per cycle; at `DIV`=1 a new bit every cycle.

## Configuration
- `SEQ_PATTERN_TX_LOOP_EN` defined:
  - Adds input port `loop` (1 bit), captured at start.
  - If captured 1, at the end of a pass: `done` pulses, `A`=`pattern[PATTERN_W-1]` again with `A_stb`, `bit_cnt`=0, state stays SHIFT, `busy` stays 1.
  - Exits only via `abort` or RST.
- Not defined: port absent; every pass ends in IDLE as described.

## Test plan
- `PATTERN_W`=8, `DIV`=4, auto, pattern 8'b1011_0110, one `start` pulse → `A` sequence 1,0,1,1,0,1,1,0; 8 `A_stb` pulses spaced 4 cycles apart; `done` 32 cycles after the first strobe; then `A`=0 and `busy`=0.
- Manual mode, same pattern, 8 `step` pulses 10 cycles apart → each bit appears 3 cycles after its step edge; `done` on the 8th edge+3; extra step pulses in IDLE produce nothing.
- Abort during bit 4 (`bit_cnt`=3), coincident with a tick → IDLE next cycle, no `done`, `A`=0; a new `start` restarts at the MSB.
- RST asserted at `bit_cnt`=5 → all outputs 0 the next cycle; `start` with `abort` also high in IDLE → no transmission.
- `start` held high, pattern 8'hA5 then changed mid-pass to 8'h3C → pass 1 emits A5 bits unchanged; pass 2 emits 3C beginning one cycle after `done`.
- With `SEQ_PATTERN_TX_LOOP_EN` and `loop`=1, pattern 8'hF0 → `done` every 8 ticks, continuous 11110000 stream; `abort` ends it.
